mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Pipelined MEM-stage load/store unit for the MIPS core: a parametrised successor to the single-cycle byte-enabled-RAM memory stage. It sits between EX/MEM and MEM/WB. It drives an external data-memory port with a req/ack handshake, so memory latency is variable. It performs little-endian lane steering for stores, load extraction with sign/zero extension for 32- or 64-bit datapaths, and misalignment detection. It also generates a pipeline stall.

## Interface
- NB_REG, 32, datapath width; 32 or 64 only.
- NB_MEM, 5, width of i_mem control bundle.
- NB_WB, 8, width of writeback control bundle.
- NB_ADDR, 32, address width.

Ports:
- i_clock  in  1  clock; all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  EX/MEM holds a valid instruction.
- i_alu_o  in  NB_ADDR  effective address (or ALU result for non-memory ops).
- i_b_o  in  NB_REG  store data.
- i_mem  in  NB_MEM  {re, we, s_u, dsize[1:0]}; dsize 00 byte, 01 half, 10 word, 11 dword; s_u=1 zero-extend, 0 sign-extend.
- i_wb  in  NB_WB  writeback controls, passed through.
- i_pc  in  NB_REG  PC, passed through.
- o_stall  out  1  upstream must hold its outputs and i_valid.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  NB_ADDR  address aligned to NB_REG/8 bytes (low bits zeroed).
- o_dmem_be  out  NB_REG/8  byte enables; bit k = bits [8k+7:8k].
- o_dmem_wdata  out  NB_REG  lane-steered store data.
- i_dmem_ack  in  1  request completed; i_dmem_rdata valid this cycle.
- i_dmem_rdata  in  NB_REG  read data.
- o_valid  out  1  one-cycle pulse; MEM/WB outputs are new.
- o_reg_wb, o_ext_mem_o  out  NB_REG  ALU result and extended load data.
- o_wb  out  NB_WB  writeback controls; forced to 0 on misalign.
- o_pc  out  NB_REG  PC.
- o_misalign  out  1  qualified by o_valid.

## Operation
- Lane offset OFF = i_alu_o[log2(NB_REG/8)-1:0].
- Misaligned when any of:
  - half and OFF[0]≠0;
  - word and OFF[1:0]≠0;
  - dword and OFF≠0;
  - dsize=11 with NB_REG=32.
- If re and we are both set, the operation is a store; re is ignored.
- Store data is replicated across lanes: byte ×(NB_REG/8), half ×(NB_REG/16), word ×(NB_REG/32).
  - Enables: byte → bit OFF; half → bits OFF+1:OFF; word → four bits from OFF; dword → all.
- Load extraction selects the sized field at byte OFF of i_dmem_rdata, then zero- or sign-extends it to NB_REG per s_u. dword passes through unchanged.
- FSM:
  - IDLE: when i_valid and not (re|we): register the pass-through fields, set o_ext_mem_o=0, pulse o_valid next cycle, stay in IDLE.
  - IDLE: when i_valid, re|we and misaligned: same as the pass-through case, plus o_wb=0 and o_misalign=1. No request is issued.
  - IDLE: when i_valid, re|we and aligned: capture address, steered data, enables, we, s_u, dsize, i_wb, i_pc and i_alu_o into internal registers; go to BUSY.
  - BUSY: o_dmem_req=1 and all o_dmem_* are driven from the captured registers, held stable until ack.
  - BUSY on i_dmem_ack: write the output registers (o_ext_mem_o = extended load data, or 0 for a store), pulse o_valid, return to IDLE.
- o_stall = (state==BUSY), combinational. i_valid is ignored while in BUSY.

## Timing
- Reset: state IDLE. o_valid, o_misalign, o_dmem_req, o_dmem_we = 0. o_dmem_be, o_dmem_addr, o_dmem_wdata, o_reg_wb, o_ext_mem_o, o_wb, o_pc = 0.
- Non-memory or misaligned op: accepted at cycle T; o_valid at T+1. Throughput is one per cycle.
- Memory op accepted at T: o_dmem_req and o_stall high from T+1. An ack at T+k (k≥1) gives o_valid at T+k+1, o_stall low at T+k+1, and the next instruction accepted at T+k+1. Minimum latency is 2 cycles.
- An ack seen while in IDLE is ignored.
- Reset asserted in BUSY: o_dmem_req=0 and state IDLE in the next cycle. The outstanding result is discarded and no o_valid is produced.
- Output registers hold their values between o_valid pulses.

## Test plan
- NB_REG=32, lb with s_u=0, addr 0x103, rdata 0x80FF_1234 → o_dmem_addr 0x100, be 0000, o_ext_mem_o 0xFFFF_FF80.
- NB_REG=32, sh, addr 0x202, i_b_o 0xDEAD_BEEF → be 1100, wdata 0xBEEF_BEEF, we=1, o_wb unchanged.
- NB_REG=64, lw with s_u=1, addr 0x0C, rdata 0x8765_4321_0000_0000 → o_dmem_addr 0x08, o_ext_mem_o 0x0000_0000_8765_4321.
- lw at 0x102 → no o_dmem_req; o_valid and o_misalign at T+1; o_wb=0. Repeat with dsize=11 at NB_REG=32 → same response.
- Ack delayed 5 cycles, with an add queued upstream → o_stall high for 5 cycles, dmem signals stable, load o_valid at T+6, add o_valid at T+7.
- Reset in the 2nd BUSY cycle, then a late ack → o_dmem_req low next cycle, no o_valid, FSM accepts normally afterward.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: lane-steers stores, extracts/extends loads and
// holds the pipeline with o_stall while a data-memory request is outstanding.
module mem_stage_lsu #(
  parameter int NB_REG  = 32,
  parameter int NB_MEM  = 5,
  parameter int NB_WB   = 8,
  parameter int NB_ADDR = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [NB_ADDR-1:0]   i_alu_o,
  input  logic [NB_REG-1:0]    i_b_o,
  input  logic [NB_MEM-1:0]    i_mem,
  input  logic [NB_WB-1:0]     i_wb,
  input  logic [NB_REG-1:0]    i_pc,
  output logic                 o_stall,
  output logic                 o_dmem_req,
  output logic                 o_dmem_we,
  output logic [NB_ADDR-1:0]   o_dmem_addr,
  output logic [NB_REG/8-1:0]  o_dmem_be,
  output logic [NB_REG-1:0]    o_dmem_wdata,
  input  logic                 i_dmem_ack,
  input  logic [NB_REG-1:0]    i_dmem_rdata,
  output logic                 o_valid,
  output logic [NB_REG-1:0]    o_reg_wb,
  output logic [NB_REG-1:0]    o_ext_mem_o,
  output logic [NB_WB-1:0]     o_wb,
  output logic [NB_REG-1:0]    o_pc,
  output logic                 o_misalign
);
  localparam int NBYTE = NB_REG / 8;
  localparam int OFFW  = $clog2(NBYTE);

  typedef enum logic {IDLE, BUSY} state_t;

  logic            re, we, su;
  logic [1:0]      dsz;
  logic [OFFW-1:0] off;
  logic            mis;
  logic [NB_REG-1:0] st_wdata_d;
  logic [NBYTE-1:0]  st_be_d;
  logic [NB_REG-1:0] ld_rsh, ld_ext;

  state_t            state_q;
  logic [NB_ADDR-1:0] addr_q;
  logic [NBYTE-1:0]   be_q;
  logic [NB_REG-1:0]  wdata_q, alu_q, pc_q;
  logic               we_q, su_q;
  logic [1:0]         dsz_q;
  logic [OFFW-1:0]    off_q;
  logic [NB_WB-1:0]   wb_q;
  logic               valid_q, misalign_q;
  logic [NB_REG-1:0]  reg_wb_q, ext_q, pc_o_q;
  logic [NB_WB-1:0]   wb_o_q;

  assign re  = i_mem[4];
  assign we  = i_mem[3];
  assign su  = i_mem[2];
  assign dsz = i_mem[1:0];
  assign off = i_alu_o[OFFW-1:0];

  always_comb begin
    mis = 1'b0;
    case (dsz)
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      2'b11:   mis = (NB_REG == 32) || (|off);
      default: mis = 1'b0;
    endcase
  end

  // Stores replicate the sized field into every lane; enables pick the lane.
  always_comb begin
    st_wdata_d = i_b_o;
    st_be_d    = '1;
    case (dsz)
      2'b00: begin
        st_wdata_d = {(NB_REG/8){i_b_o[7:0]}};
        st_be_d    = NBYTE'(1) << off;
      end
      2'b01: begin
        st_wdata_d = {(NB_REG/16){i_b_o[15:0]}};
        st_be_d    = NBYTE'(3) << off;
      end
      2'b10: begin
        st_wdata_d = {(NB_REG/32){i_b_o[31:0]}};
        st_be_d    = NBYTE'(15) << off;
      end
      default: begin
        st_wdata_d = i_b_o;
        st_be_d    = '1;
      end
    endcase
  end

  assign ld_rsh = i_dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = ld_rsh;
    case (dsz_q)
      2'b00:   ld_ext = su_q ? NB_REG'(ld_rsh[7:0])  : NB_REG'($signed(ld_rsh[7:0]));
      2'b01:   ld_ext = su_q ? NB_REG'(ld_rsh[15:0]) : NB_REG'($signed(ld_rsh[15:0]));
      2'b10:   ld_ext = su_q ? NB_REG'(ld_rsh[31:0]) : NB_REG'($signed(ld_rsh[31:0]));
      default: ld_ext = ld_rsh;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      alu_q      <= '0;
      pc_q       <= '0;
      we_q       <= 1'b0;
      su_q       <= 1'b0;
      dsz_q      <= '0;
      off_q      <= '0;
      wb_q       <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      reg_wb_q   <= '0;
      ext_q      <= '0;
      pc_o_q     <= '0;
      wb_o_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (i_valid) begin
          if (!(re | we) || mis) begin
            valid_q    <= 1'b1;
            misalign_q <= (re | we) & mis;
            reg_wb_q   <= NB_REG'(i_alu_o);
            ext_q      <= '0;
            wb_o_q     <= ((re | we) & mis) ? '0 : i_wb;
            pc_o_q     <= i_pc;
          end else begin
            // Loads read the whole word, so enables are write strobes only.
            addr_q  <= {i_alu_o[NB_ADDR-1:OFFW], OFFW'(0)};
            be_q    <= we ? st_be_d : '0;
            wdata_q <= st_wdata_d;
            we_q    <= we;
            su_q    <= su;
            dsz_q   <= dsz;
            off_q   <= off;
            wb_q    <= i_wb;
            pc_q    <= i_pc;
            alu_q   <= NB_REG'(i_alu_o);
            state_q <= BUSY;
          end
        end
        BUSY: if (i_dmem_ack) begin
          valid_q    <= 1'b1;
          misalign_q <= 1'b0;
          reg_wb_q   <= alu_q;
          ext_q      <= we_q ? '0 : ld_ext;
          wb_o_q     <= wb_q;
          pc_o_q     <= pc_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_stall      = (state_q == BUSY);
  assign o_dmem_req   = (state_q == BUSY);
  assign o_dmem_we    = (state_q == BUSY) & we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_valid      = valid_q;
  assign o_misalign   = misalign_q;
  assign o_reg_wb     = reg_wb_q;
  assign o_ext_mem_o  = ext_q;
  assign o_wb         = wb_o_q;
  assign o_pc         = pc_o_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: one 32-bit and one 64-bit instance.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        v32, v64;
  logic [31:0] alu;
  logic [63:0] b, pc, rdata;
  logic [4:0]  mem;
  logic [7:0]  wb;
  logic        ack;

  logic        stall32, req32, we32, valid32, mis32;
  logic [31:0] addr32, wdata32, regwb32, ext32, pco32;
  logic [3:0]  be32;
  logic [7:0]  wbo32;

  logic        stall64, req64, we64, valid64, mis64;
  logic [31:0] addr64;
  logic [63:0] wdata64, regwb64, ext64, pco64;
  logic [7:0]  be64, wbo64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.NB_REG(32)) u32 (
    .i_clock(clk), .i_reset(rst), .i_valid(v32), .i_alu_o(alu), .i_b_o(b[31:0]),
    .i_mem(mem), .i_wb(wb), .i_pc(pc[31:0]), .o_stall(stall32), .o_dmem_req(req32),
    .o_dmem_we(we32), .o_dmem_addr(addr32), .o_dmem_be(be32), .o_dmem_wdata(wdata32),
    .i_dmem_ack(ack), .i_dmem_rdata(rdata[31:0]), .o_valid(valid32), .o_reg_wb(regwb32),
    .o_ext_mem_o(ext32), .o_wb(wbo32), .o_pc(pco32), .o_misalign(mis32));

  mem_stage_lsu #(.NB_REG(64)) u64 (
    .i_clock(clk), .i_reset(rst), .i_valid(v64), .i_alu_o(alu), .i_b_o(b),
    .i_mem(mem), .i_wb(wb), .i_pc(pc), .o_stall(stall64), .o_dmem_req(req64),
    .o_dmem_we(we64), .o_dmem_addr(addr64), .o_dmem_be(be64), .o_dmem_wdata(wdata64),
    .i_dmem_ack(ack), .i_dmem_rdata(rdata), .o_valid(valid64), .o_reg_wb(regwb64),
    .o_ext_mem_o(ext64), .o_wb(wbo64), .o_pc(pco64), .o_misalign(mis64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; v32 = 1'b0; v64 = 1'b0; alu = '0; b = '0; pc = '0;
    rdata = '0; mem = '0; wb = '0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", valid32, 0);
    chk("rst_req",   req32, 0);
    chk("rst_stall", stall32, 0);
    chk("rst_we",    we32, 0);
    chk("rst_be",    be32, 0);
    chk("rst_addr",  addr32, 0);
    chk("rst_ext",   ext32, 0);
    chk("rst_wb",    wbo32, 0);
    chk("rst_pc",    pco32, 0);

    // lb signed at 0x103
    alu = 32'h103; mem = 5'b10000; wb = 8'hA5; pc = 64'h40; v32 = 1'b1;
    tick(); v32 = 1'b0;
    chk("lb_req",   req32, 1);
    chk("lb_stall", stall32, 1);
    chk("lb_addr",  addr32, 32'h100);
    chk("lb_be",    be32, 4'b0000);
    chk("lb_we",    we32, 0);
    rdata = 64'h80FF_1234; ack = 1'b1;
    tick(); ack = 1'b0;
    chk("lb_valid", valid32, 1);
    chk("lb_ext",   ext32, 32'hFFFF_FF80);
    chk("lb_regwb", regwb32, 32'h103);
    chk("lb_wb",    wbo32, 8'hA5);
    chk("lb_pc",    pco32, 32'h40);
    chk("lb_mis",   mis32, 0);
    chk("lb_stall_lo", stall32, 0);
    tick();
    chk("lb_pulse", valid32, 0);
    chk("lb_hold",  ext32, 32'hFFFF_FF80);

    // sh at 0x202
    alu = 32'h202; b = 64'hDEAD_BEEF; mem = 5'b01001; wb = 8'h3C; pc = 64'h44; v32 = 1'b1;
    tick(); v32 = 1'b0;
    chk("sh_be",    be32, 4'b1100);
    chk("sh_wdata", wdata32, 32'hBEEF_BEEF);
    chk("sh_we",    we32, 1);
    chk("sh_req",   req32, 1);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("sh_valid", valid32, 1);
    chk("sh_ext",   ext32, 0);
    chk("sh_wb",    wbo32, 8'h3C);

    // misaligned lw, then dword on 32-bit datapath
    alu = 32'h102; mem = 5'b10010; wb = 8'hFF; pc = 64'h48; v32 = 1'b1;
    tick();
    chk("mis_req",   req32, 0);
    chk("mis_valid", valid32, 1);
    chk("mis_flag",  mis32, 1);
    chk("mis_wb",    wbo32, 0);
    chk("mis_stall", stall32, 0);
    chk("mis_regwb", regwb32, 32'h102);
    alu = 32'h100; mem = 5'b10011;
    tick();
    chk("mis64_req",   req32, 0);
    chk("mis64_valid", valid32, 1);
    chk("mis64_flag",  mis32, 1);
    chk("mis64_wb",    wbo32, 0);

    // non-memory op
    alu = 32'h1234; mem = 5'b00000; wb = 8'h11; pc = 64'h4C;
    tick(); v32 = 1'b0;
    chk("add_valid", valid32, 1);
    chk("add_mis",   mis32, 0);
    chk("add_wb",    wbo32, 8'h11);
    chk("add_regwb", regwb32, 32'h1234);
    chk("add_ext",   ext32, 0);

    // lw with 5-cycle ack delay and an add queued behind it
    alu = 32'h300; mem = 5'b10010; wb = 8'h22; pc = 64'h50; v32 = 1'b1;
    tick();
    alu = 32'h55; mem = 5'b00000; wb = 8'h33; pc = 64'h54;
    for (int i = 0; i < 5; i++) begin
      chk("dly_stall", stall32, 1);
      chk("dly_req",   req32, 1);
      chk("dly_addr",  addr32, 32'h300);
      chk("dly_we",    we32, 0);
      chk("dly_valid", valid32, 0);
      if (i == 4) begin rdata = 64'h1234_5678; ack = 1'b1; end
      tick();
    end
    ack = 1'b0;
    chk("dly_ld_valid", valid32, 1);
    chk("dly_ld_ext",   ext32, 32'h1234_5678);
    chk("dly_ld_wb",    wbo32, 8'h22);
    chk("dly_stall_lo", stall32, 0);
    tick(); v32 = 1'b0;
    chk("dly_add_valid", valid32, 1);
    chk("dly_add_regwb", regwb32, 32'h55);
    chk("dly_add_wb",    wbo32, 8'h33);
    chk("dly_add_req",   req32, 0);

    // reset during the 2nd BUSY cycle, then a late ack
    alu = 32'h400; mem = 5'b10010; wb = 8'h66; v32 = 1'b1;
    tick(); v32 = 1'b0;
    tick();
    chk("rb_req", req32, 1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rb_req_lo",  req32, 0);
    chk("rb_stall",   stall32, 0);
    chk("rb_valid",   valid32, 0);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("rb_late_valid", valid32, 0);
    chk("rb_late_req",   req32, 0);
    alu = 32'h77; mem = 5'b00000; wb = 8'h44; v32 = 1'b1;
    tick(); v32 = 1'b0;
    chk("rb_after_valid", valid32, 1);
    chk("rb_after_regwb", regwb32, 32'h77);

    // 64-bit datapath: lw unsigned at 0x0C
    alu = 32'h0C; mem = 5'b10110; wb = 8'h01; v64 = 1'b1;
    tick(); v64 = 1'b0;
    chk("w64_addr", addr64, 32'h08);
    chk("w64_req",  req64, 1);
    chk("w64_be",   be64, 8'h00);
    rdata = 64'h8765_4321_0000_0000; ack = 1'b1;
    tick(); ack = 1'b0;
    chk("w64_valid", valid64, 1);
    chk("w64_ext",   ext64, 64'h0000_0000_8765_4321);
    chk("w64_idle32", valid32, 0);

    // 64-bit lh signed at 0x06
    alu = 32'h06; mem = 5'b10001; v64 = 1'b1;
    tick(); v64 = 1'b0;
    rdata = 64'h8001_0000_0000_0000; ack = 1'b1;
    tick(); ack = 1'b0;
    chk("h64_ext", ext64, 64'hFFFF_FFFF_FFFF_8001);

    // 64-bit sb at 0x15
    alu = 32'h15; b = 64'hAB; mem = 5'b01000; v64 = 1'b1;
    tick(); v64 = 1'b0;
    chk("b64_addr",  addr64, 32'h10);
    chk("b64_be",    be64, 8'b0010_0000);
    chk("b64_wdata", wdata64, 64'hABAB_ABAB_ABAB_ABAB);
    chk("b64_we",    we64, 1);
    ack = 1'b1;
    tick(); ack = 1'b0;
    chk("b64_valid", valid64, 1);
    chk("b64_ext",   ext64, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
